sparse_event_encoder: RTL and testbench
=======================================

# sparse_event_encoder

Upstream stage of the sparse serializer/deserializer. It converts a dense SIZE-bit activity vector into a stream of sparse event addresses, lowest index first, over a valid/ready handshake. It signals end-of-frame with `last` and a one-cycle `done` pulse. Its `addr_out` stream is the `addr_in` source for the serializer.

## Interface
- `SIZE`, default 8: width of the dense vector, ≥2, power of two.
- `ADDR_W`, default `$clog2(SIZE)`: address width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  when low, all state frozen and `load` ignored; outputs hold.
- `load`  in  1  capture `vec_in` and start a frame. Honoured only in IDLE.
- `vec_in`  in  SIZE  dense activity vector; bit i set means event at address i.
- `addr_out`  out  ADDR_W  address of the current pending event.
- `addr_valid`  out  1  `addr_out` is valid.
- `addr_ready`  in  1  consumer accepts `addr_out` this cycle.
- `last`  out  1  the current address is the final event of the frame.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at end of frame.
- `count_out`  out  ADDR_W+1  number of events accepted in the current or most recent frame.

## Operation
- States:
  - IDLE: waiting for `load`.
  - SCAN: emitting addresses.
  - DONE: one cycle, `done`=1.
- Transitions:
  - IDLE + `load`, with `vec_in`≠0 → SCAN.
  - IDLE + `load`, with `vec_in`=0 → DONE.
  - SCAN + handshake on the final set bit → DONE.
  - DONE → IDLE unconditionally.
- Register `pending[SIZE-1:0]` is loaded from `vec_in`, and `count_out` is cleared, on an accepted `load`.
- `addr_out` = index of the lowest set bit of `pending`, decoded from registered state only. There is no combinational path from inputs to outputs.
- `addr_valid` = (state==SCAN).
- `last` = `addr_valid` and `pending` has exactly one bit set.
- Handshake: `addr_valid`&`addr_ready`&`enable` clears the lowest set bit of `pending` and increments `count_out`. No saturation is needed, since the maximum value is SIZE and fits in ADDR_W+1 bits.
- Once raised, `addr_valid` stays high and `addr_out` stays stable until the handshake completes.
- `load` while busy is ignored: no capture, no error.
- Outside SCAN, `addr_out` drives 0.
- Reset values:
  - state=IDLE, `pending`=0, `count_out`=0.
  - Outputs: `addr_out`=0, `addr_valid`=0, `last`=0, `busy`=0, `done`=0.

## Timing
- `load` sampled at edge N → `addr_valid` high in cycle N+1, showing the lowest set index.
- Throughput is 1 address/cycle with `addr_ready` held high. A K-bit frame occupies SCAN for exactly K cycles.
- After the final handshake at edge M: `done`=1 in cycle M+1, `busy`=0 in cycle M+2. The earliest new `load` is accepted at edge M+2.
- Zero vector: load at edge N → `done`=1 in cycle N+1, `count_out`=0, no `addr_valid`.
- `addr_ready` low: state and outputs hold indefinitely.
- `enable` low mid-frame: everything, including a pending `done`, is delayed cycle-for-cycle. It is never lost.
- `rst_n` asserted mid-frame: immediate return to reset values. `done` is not pulsed and the partial frame is discarded.

## Structure
- Package `sparse_pkg`:
  - `state_t` enum {IDLE, SCAN, DONE}.
  - Shared `SIZE` default and address-width function, reused by the serializer for its instruction/address types.
- Sub-module `sparse_prienc`, parameterised by SIZE. It is purely combinational and produces:
  - lowest-set-bit index;
  - one-hot clear mask;
  - `onehot` flag (popcount==1);
  - `any` flag.
- Top holds the FSM, `pending`, `count_out` and handshake logic. Target is ~150–250 lines total.

## Test plan
- Reset, then load `vec_in`=8'b1010_0100 with `addr_ready`=1:
  - addresses 2, 5, 7 on consecutive cycles;
  - `last` only with 7;
  - `done` one cycle later, `count_out`=3.
- Load 8'h00 → `done` pulse in the cycle after load, no `addr_valid`, `count_out`=0, `busy` low after one further cycle.
- Load 8'hFF with `addr_ready` toggling 1,0,0,1,… → `addr_out` stable while stalled, all addresses 0..7 emitted in order, `count_out`=8.
- Load 8'b0001_0010, then assert `load` with 8'hFF during SCAN → second load ignored, only 1 and 4 emitted.
- `enable` low for 3 cycles mid-frame on 8'h81 → frame completes with 0 then 7, and `done` is delayed by exactly 3 cycles.
- `rst_n` pulsed low asynchronously (mid-cycle) during SCAN of 8'h0F → outputs reset immediately without waiting for a clock edge, no `done`, and a subsequent load of 8'h01 emits address 0.

Source files
------------

// File: rtl/sparse_pkg.sv
// Shared types and sizing helpers for the sparse encoder/serializer family.
package sparse_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SIZE_DEF = 8;

   function automatic int addr_w(input int size);
      return (size > 2) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/sparse_prienc.sv
// Combinational lowest-set-bit priority encoder with clear mask and population flags.
module sparse_prienc
   import sparse_pkg::*;
#(
   parameter int SIZE   = SIZE_DEF,
   parameter int ADDR_W = addr_w(SIZE)
) (
   input  logic [SIZE-1:0]   vec,
   output logic [ADDR_W-1:0] idx,
   output logic [SIZE-1:0]   mask,
   output logic              onehot,
   output logic              any
);

   always_comb begin
      idx = '0;
      for (int i = SIZE - 1; i >= 0; i--) begin
         if (vec[i]) idx = i[ADDR_W-1:0];
      end
   end

   // Two's-complement trick isolates the lowest set bit; clearing it leaves zero iff one-hot.
   assign mask   = vec & (~vec + SIZE'(1));
   assign any    = |vec;
   assign onehot = any && ((vec & (vec - SIZE'(1))) == '0);

endmodule

// File: rtl/sparse_event_encoder.sv
// Dense activity vector to sparse address stream, lowest index first, valid/ready output.
module sparse_event_encoder
   import sparse_pkg::*;
#(
   parameter int SIZE   = SIZE_DEF,
   parameter int ADDR_W = addr_w(SIZE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              load,
   input  logic [SIZE-1:0]   vec_in,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic              last,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count_out
);

   state_t            state, state_nxt;
   logic [SIZE-1:0]   pending;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] low_idx;
   logic [SIZE-1:0]   low_mask;
   logic              low_onehot;
   logic              low_any;
   logic              accept_load;
   logic              handshake;

   sparse_prienc #(
      .SIZE   (SIZE),
      .ADDR_W (ADDR_W)
   ) u_prienc (
      .vec    (pending),
      .idx    (low_idx),
      .mask   (low_mask),
      .onehot (low_onehot),
      .any    (low_any)
   );

   assign accept_load = enable && load && (state == IDLE);
   assign handshake   = enable && addr_ready && (state == SCAN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (enable) begin
         case (state)
            IDLE:    if (load) state_nxt = (vec_in != '0) ? SCAN : DONE;
            SCAN:    if (addr_ready && low_onehot) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         count   <= '0;
      end else if (accept_load) begin
         pending <= vec_in;
         count   <= '0;
      end else if (handshake) begin
         pending <= pending & ~low_mask;
         count   <= count + (ADDR_W + 1)'(1);
      end
   end

   // Outputs decode registered state only, so reset takes effect without a clock edge.
   assign addr_valid = (state == SCAN);
   assign addr_out   = addr_valid ? low_idx : '0;
   assign last       = addr_valid && low_onehot;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign count_out  = count;

endmodule

// File: tb/tb_sparse_event_encoder.sv
// Randomized and directed bench for sparse_event_encoder against a queue-based model.
module tb_sparse_event_encoder;

   localparam int SIZE   = 8;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              load;
   logic [SIZE-1:0]   vec_in;
   logic [ADDR_W-1:0] addr_out;
   logic              addr_valid;
   logic              addr_ready;
   logic              last;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   count_out;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining addresses of the frame, pending done pulse, accepted count.
   int m_q[$];
   bit m_done;
   int m_cnt;
   int cyc     = 0;
   int done_at = -1;

   sparse_event_encoder #(.SIZE(SIZE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .vec_in     (vec_in),
      .addr_out   (addr_out),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .last       (last),
      .busy       (busy),
      .done       (done),
      .count_out  (count_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit m_idle();
      return (m_q.size() == 0) && !m_done;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_done = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_edge();
      if (!enable) return;
      if (m_done) begin
         m_done = 1'b0;
      end else if (m_q.size() > 0) begin
         if (addr_ready) begin
            void'(m_q.pop_front());
            m_cnt++;
            if (m_q.size() == 0) m_done = 1'b1;
         end
      end else if (load) begin
         m_cnt = 0;
         for (int i = 0; i < SIZE; i++) if (vec_in[i]) m_q.push_back(i);
         if (m_q.size() == 0) m_done = 1'b1;
      end
   endtask

   task automatic check_outputs();
      bit v;
      v = (m_q.size() > 0);
      check("addr_valid", 32'(addr_valid), 32'(v));
      check("addr_out", 32'(addr_out), v ? 32'(m_q[0]) : 32'd0);
      check("last", 32'(last), 32'(m_q.size() == 1));
      check("busy", 32'(busy), 32'(v || m_done));
      check("done", 32'(done), 32'(m_done));
      check("count_out", 32'(count_out), 32'(m_cnt));
   endtask

   task automatic tick();
      check_outputs();
      if (done && done_at < 0) done_at = cyc;
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   // rmode 0: ready held high; rmode 1: ready pattern 1,0,0,1,0,0...
   task automatic frame(input logic [SIZE-1:0] v, input int rmode);
      load = 1'b1; vec_in = v; addr_ready = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 60 && !m_idle(); i++) begin
         addr_ready = (rmode == 0) ? 1'b1 : ((i % 3) == 0);
         tick();
      end
      if (!m_idle()) check("frame_timeout", 32'd0, 32'd1);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; load = 1'b0; vec_in = '0; addr_ready = 1'b0;
      model_reset();
      #12;
      check_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;

      frame(8'b1010_0100, 0);
      frame(8'h00, 0);
      frame(8'hFF, 1);

      // Load while busy must be ignored.
      load = 1'b1; vec_in = 8'b0001_0010; addr_ready = 1'b1;
      tick();
      vec_in = 8'hFF;
      for (int i = 0; i < 20 && !m_idle(); i++) begin
         load = !m_idle();
         tick();
      end
      load = 1'b0;
      tick();

      // Enable low for three cycles mid-frame stretches the frame by three cycles.
      load = 1'b1; vec_in = 8'h81; addr_ready = 1'b1;
      tick();
      load = 1'b0; done_at = -1;
      begin
         int start;
         start = cyc;
         tick();
         enable = 1'b0;
         repeat (3) tick();
         enable = 1'b1;
         for (int i = 0; i < 10 && !m_idle(); i++) tick();
         check("done_latency", 32'(done_at - start), 32'd5);
      end
      tick();

      // Asynchronous reset mid-cycle during a scan.
      load = 1'b1; vec_in = 8'h0F; addr_ready = 1'b1;
      tick();
      load = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      frame(8'h01, 0);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         load       = ($urandom_range(0, 3) == 0);
         vec_in     = ($urandom_range(0, 7) == 0) ? 8'h00 : SIZE'($urandom);
         addr_ready = ($urandom_range(0, 3) != 0);
         enable     = ($urandom_range(0, 5) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
